mpf_vtp_tlb_responder: RTL
==========================

# mpf_vtp_tlb_responder

Responder end of a VTP translation port: serves address-translation requests from a translating client such as the Avalon read/write request translator. Each virtual line address is looked up in a small fully associative TLB of 4KB pages. A miss fetches the mapping from an external page walker, fills the TLB, then responds. Non-virtual addresses pass through unchanged. One request is in flight at a time, and responses return in request order.

## Interface
Parameters:
- ADDR_WIDTH, 42: line-address width (64B lines), for both VA and PA.
- PAGE_OFFSET_BITS, 6: line-address bits inside a 4KB page. VPN/PPN width is ADDR_WIDTH-PAGE_OFFSET_BITS.
- N_ENTRIES, 16: TLB entries. Power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  translation request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  ADDR_WIDTH  line address.
- req_addr_is_virtual  in  1  0 = pass through untranslated.
- req_is_speculative  in  1  1 = a walk error returns rsp_error instead of halting.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_addr  out  ADDR_WIDTH  translated address; the original address on error.
- rsp_error  out  1  translation failed.
- walk_req_valid / walk_req_ready  out / in  1 / 1  page-walk request handshake.
- walk_req_vpn  out  VPN width  page to walk.
- walk_rsp_valid  in  1  walk result valid. Always accepted.
- walk_rsp_ppn  in  PPN width  physical page.
- walk_rsp_error  in  1  no mapping.
- inval  in  1  one-cycle pulse: invalidate all entries.
- halted  out  1  sticky: a non-speculative translation failed.
- hit_cnt, miss_cnt  out  32  saturating statistics counters.

## Operation
- FSM states: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP, HALT.
- IDLE: req_ready=1. On handshake, register addr and flags, then go to LOOKUP.
- LOOKUP: compare the VPN against all valid entries in parallel.
  - Non-virtual: rsp_addr = req_addr, then RESP.
  - Hit: rsp_addr = {entry PPN, req offset}, hit_cnt++, then RESP.
  - Miss: miss_cnt++, then WALK_REQ.
- WALK_REQ: walk_req_valid=1 with the registered VPN. Hold the request until walk_req_ready, then WALK_WAIT.
- WALK_WAIT: on walk_rsp_valid:
  - No error: write {valid, VPN, PPN} to the entry at the round-robin pointer, advance the pointer (N_ENTRIES-1 wraps to 0), set rsp_addr, go to RESP.
  - Error, speculative: rsp_error=1, rsp_addr = original, nothing inserted, go to RESP.
  - Error, non-speculative: set halted and go to HALT.
- RESP: rsp_valid=1. Outputs are held stable until rsp_ready, then IDLE.
- HALT: terminal until reset. req_ready=0, rsp_valid=0, walk_req_valid=0.
- Entries are inserted only on a miss, so no duplicate VPNs exist. Errors are never cached.
- inval:
  - Clears all valid bits the same cycle. Pointer and counters are unchanged.
  - inval in LOOKUP: the compare uses the pre-invalidate state.
  - inval while in WALK_REQ or WALK_WAIT: the pending fill is still returned in rsp but is not inserted.
  - inval coinciding with a fill write: inval wins, and the entry ends invalid.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset: all outputs 0, FSM in IDLE, entries invalid, pointer 0, counters 0. req_ready rises on the first clock after reset deasserts.
- Reset asserted mid-operation aborts immediately. A walk response arriving after reset is ignored, because the FSM is in IDLE.
- Hit or pass-through: request handshake at edge T, rsp_valid high in cycle T+2 (IDLE→LOOKUP→RESP). Sustained throughput is 1 request per 3 cycles with rsp_ready=1.
- Miss: rsp_valid asserts 1 cycle after the walk_rsp_valid cycle. walk_req_valid asserts 2 cycles after the request handshake.
- req_ready is combinational from state only. It has no dependency on req_valid or rsp_ready.
- All other outputs are registered.

## Test plan
- Pass-through: addr_is_virtual=0, addr 0x123_4567 → rsp_addr 0x123_4567 at T+2, no walk, counters unchanged.
- Miss then hit:
  - VA 0x40 (VPN 1): walker returns PPN 0x7 → rsp_addr 0x1C0, miss_cnt=1.
  - Repeat with VA 0x7F → rsp_addr 0x1FF at T+2, hit_cnt=1, no walk.
- Replacement wrap: fill VPNs 0..16 with N_ENTRIES=16 → VPN 0 evicted (pointer wrapped to 0, now 1). Re-request VPN 0 → walk issued. VPN 1 still hits.
- Errors:
  - Speculative walk error → rsp_error=1, rsp_addr = original VA. A repeat request walks again.
  - Non-speculative walk error → halted=1, req_ready stuck at 0 until reset_n pulse.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp stable, req_ready=0. Hold walk_req_ready=0 for 3 cycles → walk_req_vpn stable.
- Invalidate:
  - inval after a fill → same VA misses.
  - inval during WALK_WAIT → response delivered with the correct PA, next request to that VPN walks again.

Source files
------------

// File: rtl/mpf_vtp_tlb_responder.sv
// VTP translation responder: fully associative 4KB-page TLB with a round-robin
// fill, an external page-walk miss path and in-order single-outstanding responses.
module mpf_vtp_tlb_responder #(
  parameter int ADDR_WIDTH       = 42,
  parameter int PAGE_OFFSET_BITS = 6,
  parameter int N_ENTRIES        = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [ADDR_WIDTH-1:0]                  req_addr,
  input  logic                                   req_addr_is_virtual,
  input  logic                                   req_is_speculative,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [ADDR_WIDTH-1:0]                  rsp_addr,
  output logic                                   rsp_error,
  output logic                                   walk_req_valid,
  input  logic                                   walk_req_ready,
  output logic [ADDR_WIDTH-PAGE_OFFSET_BITS-1:0] walk_req_vpn,
  input  logic                                   walk_rsp_valid,
  input  logic [ADDR_WIDTH-PAGE_OFFSET_BITS-1:0] walk_rsp_ppn,
  input  logic                                   walk_rsp_error,
  input  logic                                   inval,
  output logic                                   halted,
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt
);

  localparam int VPN_W = ADDR_WIDTH - PAGE_OFFSET_BITS;
  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP, HALT
  } state_t;

  state_t                  state_q, state_d;
  logic                    active_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    virt_q, virt_d;
  logic                    spec_q, spec_d;
  logic                    kill_q, kill_d;
  logic [N_ENTRIES-1:0]    valid_q, valid_d;
  logic [VPN_W-1:0]        vpn_q [N_ENTRIES];
  logic [VPN_W-1:0]        vpn_d [N_ENTRIES];
  logic [VPN_W-1:0]        ppn_q [N_ENTRIES];
  logic [VPN_W-1:0]        ppn_d [N_ENTRIES];
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;
  logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    walk_req_valid_q, walk_req_valid_d;
  logic                    halted_q, halted_d;

  logic [VPN_W-1:0]        cur_vpn;
  logic                    hit;
  logic [VPN_W-1:0]        hit_ppn;

  assign cur_vpn        = addr_q[ADDR_WIDTH-1:PAGE_OFFSET_BITS];
  // active_q holds req_ready low until the first clock after reset release
  assign req_ready      = active_q && (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_addr       = rsp_addr_q;
  assign rsp_error      = rsp_error_q;
  assign walk_req_valid = walk_req_valid_q;
  assign walk_req_vpn   = cur_vpn;
  assign halted         = halted_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

  // VPNs are unique among valid entries, so OR-ing matching PPNs selects one
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == cur_vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ppn_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    virt_d      = virt_q;
    spec_d      = spec_q;
    kill_d      = kill_q;
    valid_d     = valid_q;
    vpn_d       = vpn_q;
    ppn_d       = ppn_q;
    ptr_d       = ptr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_error_d = rsp_error_q;
    halted_d    = halted_q;

    case (state_q)
      IDLE: begin
        if (req_valid && active_q) begin
          addr_d  = req_addr;
          virt_d  = req_addr_is_virtual;
          spec_d  = req_is_speculative;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        kill_d = 1'b0;
        if (!virt_q) begin
          rsp_addr_d  = addr_q;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else if (hit) begin
          rsp_addr_d  = {hit_ppn, addr_q[PAGE_OFFSET_BITS-1:0]};
          rsp_error_d = 1'b0;
          hit_cnt_d   = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 32'd1;
          state_d     = RESP;
        end else begin
          miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
          state_d     = WALK_REQ;
        end
      end
      WALK_REQ: begin
        if (inval) kill_d = 1'b1;
        if (walk_req_ready) state_d = WALK_WAIT;
      end
      WALK_WAIT: begin
        if (inval) kill_d = 1'b1;
        if (walk_rsp_valid) begin
          if (!walk_rsp_error) begin
            if (!kill_q && !inval) begin
              valid_d[ptr_q] = 1'b1;
              vpn_d[ptr_q]   = cur_vpn;
              ppn_d[ptr_q]   = walk_rsp_ppn;
              ptr_d = (ptr_q == IDX_W'(N_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
            end
            rsp_addr_d  = {walk_rsp_ppn, addr_q[PAGE_OFFSET_BITS-1:0]};
            rsp_error_d = 1'b0;
            state_d     = RESP;
          end else if (spec_q) begin
            rsp_addr_d  = addr_q;
            rsp_error_d = 1'b1;
            state_d     = RESP;
          end else begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Applied after the FSM so an invalidate overrides a same-cycle fill
    if (inval) valid_d = '0;

    rsp_valid_d      = (state_d == RESP);
    walk_req_valid_d = (state_d == WALK_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      active_q         <= 1'b0;
      addr_q           <= '0;
      virt_q           <= 1'b0;
      spec_q           <= 1'b0;
      kill_q           <= 1'b0;
      valid_q          <= '0;
      ptr_q            <= '0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
      rsp_addr_q       <= '0;
      rsp_error_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      walk_req_valid_q <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      active_q         <= 1'b1;
      addr_q           <= addr_d;
      virt_q           <= virt_d;
      spec_q           <= spec_d;
      kill_q           <= kill_d;
      valid_q          <= valid_d;
      ptr_q            <= ptr_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      rsp_addr_q       <= rsp_addr_d;
      rsp_error_q      <= rsp_error_d;
      rsp_valid_q      <= rsp_valid_d;
      walk_req_valid_q <= walk_req_valid_d;
      halted_q         <= halted_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    vpn_q <= vpn_d;
    ppn_q <= ppn_d;
  end

endmodule
